rv_multicycle_control: RTL and testbench
========================================

Name: rv_multicycle_control

Overview:
- Main control FSM of the multicycle RV32I core; sits directly upstream of ALU_Control.
- Decodes the IR opcode and sequences fetch/decode/execute/memory/writeback.
- Drives ALU_CO_o and is_immediate_o straight into ALU_Control (FUNC3/FUNC7 go there from the IR).
- Also drives all datapath mux selects and write enables, and stalls on the memory ready handshake.

Parameters:
- STALL_LIMIT, 0, max consecutive wait cycles in a memory state before bus error; 0 disables the timeout (wait forever).

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- opcode_i  input  7  IR[6:0], stable from DECODE until the next FETCH completes
- mem_ready_i  input  1  memory completes current access this cycle
- branch_taken_i  input  1  ALU compare result; 1 = branch condition true
- pc_write_o  output  1  PC load enable
- ir_write_o  output  1  IR/oldPC load enable
- adr_src_o  output  1  memory address: 0 PC, 1 ALUOut
- mem_write_o  output  1  memory write request
- reg_write_o  output  1  register file write
- alu_src_a_o  output  2  00 PC, 01 oldPC, 10 rs1, 11 zero
- alu_src_b_o  output  2  00 rs2, 01 imm, 10 const 4
- result_src_o  output  2  00 ALUOut, 01 mem data, 10 ALU result
- ALU_CO_o  output  2  to ALU_Control: 00 add, 01 branch compare, 10 R/I decode
- is_immediate_o  output  1  to ALU_Control: 1 in EXECUTEI only
- illegal_instr_o  output  1  one-cycle pulse, unknown opcode
- bus_error_o  output  1  one-cycle pulse, memory timeout
- state_o  output  4  current state, debug/verification

Behaviour:
State encoding:
- FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
- EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12

Reset:
- state=FETCH and wait counter=0, asynchronously.
- While rst_i is high, pc_write_o, ir_write_o, mem_write_o, reg_write_o, illegal_instr_o and bus_error_o are forced 0.
- All other outputs show FETCH values.

Output rules:
- Outputs are combinational from state; any field not listed for a state is 0.
- pc_write_o = pc_update | (branch & branch_taken_i).

States:
- FETCH: adr_src=0, a=00, b=10, CO=00, result_src=10. ir_write=pc_update=mem_ready_i. Stay until mem_ready_i, then DECODE.
- DECODE: a=01, b=01, CO=00 (branch target / AUIPC result to ALUOut). Next state by opcode:
  - 0000011, 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> ALUWB
  - any other opcode -> FETCH with illegal_instr_o=1 this cycle.
- MEMADR: a=10, b=01, CO=00. -> MEMREAD for load, MEMWRITE for store.
- MEMREAD: adr_src=1. Wait for mem_ready_i, then MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held until mem_ready_i, then FETCH.
- EXECUTER: a=10, b=00, CO=10, is_immediate=0 -> ALUWB.
- EXECUTEI: a=10, b=01, CO=10, is_immediate=1 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: a=10, b=00, CO=01, result_src=00, branch=1 -> FETCH.
- JAL: a=01, b=10, CO=00, result_src=00, pc_update=1 (PC <- ALUOut target) -> ALUWB (rd <- oldPC+4).
- JALR: a=10, b=01, CO=00 -> JAL.
- LUI: a=11, b=01, CO=00 -> ALUWB.

Stall counter:
- Counts consecutive cycles in FETCH/MEMREAD/MEMWRITE with mem_ready_i=0; cleared on any state change.
- If STALL_LIMIT!=0 and the count reaches STALL_LIMIT: pulse bus_error_o, go to FETCH, no write enables that cycle.
- mem_ready_i in the same cycle as the limit wins: normal transition, no error.
- Counter saturates; it never wraps.

Other boundary conditions:
- Reset mid-instruction aborts it; no partial writes after reset assertion.
- branch_taken_i is ignored outside BRANCH.

Test Plan:
- Reset then mem_ready_i=1, opcode 0110011 -> states 0,1,6,8,0. In state 6: ALU_CO_o=10, is_immediate_o=0. reg_write_o=1 only in state 8.
- Opcode 0010011 -> EXECUTEI with ALU_CO_o=10, is_immediate_o=1, alu_src_b_o=01.
- Load with mem_ready_i low 3 cycles in MEMREAD, STALL_LIMIT=0 -> stays in state 3 for 4 cycles, then 4 with result_src_o=01 and reg_write_o=1.
- BRANCH with branch_taken_i=1 -> pc_write_o=1, ALU_CO_o=01. Repeat with 0 -> pc_write_o=0. Both return to FETCH.
- JALR -> states 11,10,8. pc_write_o=1 in 10, alu_src_a_o=01 and alu_src_b_o=10 in 10.
- Opcode 1111111 -> illegal_instr_o pulses in DECODE, next state FETCH. STALL_LIMIT=4 with mem_ready_i=0 in FETCH -> bus_error_o pulses on the 4th wait cycle. Async reset mid-MEMWRITE -> mem_write_o drops immediately, state_o=0.

Source files
------------

// File: rtl/rv_multicycle_control.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives ALU_Control.
module rv_multicycle_control #(
    parameter int STALL_LIMIT = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       branch_taken_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [1:0] ALU_CO_o,
    output logic       is_immediate_o,
    output logic       illegal_instr_o,
    output logic       bus_error_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [15:0] LIM_M1 =
        16'(STALL_LIMIT > 0 ? STALL_LIMIT - 1 : 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wait_st, stalled, timeout, illegal;
    logic        pc_update, branch, mem_wr_raw, reg_wr_raw, ir_wr_raw;

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD)
                  || (state_q == S_MEMWRITE);
    assign stalled = wait_st && !mem_ready_i;
    // The STALL_LIMIT-th consecutive wait cycle is the one that errors.
    assign timeout = (STALL_LIMIT != 0) && stalled && (cnt_q >= LIM_M1);

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        unique case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (opcode_i == OP_STORE) ? S_MEMWRITE
                                                         : S_MEMREAD;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_LUI:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_FETCH;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (timeout || state_d != state_q) cnt_d = '0;
        else if (stalled && cnt_q != '1) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_update      = 1'b0;
        branch         = 1'b0;
        ir_wr_raw      = 1'b0;
        mem_wr_raw     = 1'b0;
        reg_wr_raw     = 1'b0;
        adr_src_o      = 1'b0;
        alu_src_a_o    = 2'b00;
        alu_src_b_o    = 2'b00;
        result_src_o   = 2'b00;
        ALU_CO_o       = 2'b00;
        is_immediate_o = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_wr_raw    = mem_ready_i;
                pc_update    = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
            end
            S_MEMREAD:  adr_src_o = 1'b1;
            S_MEMWB: begin
                result_src_o = 2'b01;
                reg_wr_raw   = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_o  = 1'b1;
                mem_wr_raw = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_o = 2'b10;
                ALU_CO_o    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a_o    = 2'b10;
                alu_src_b_o    = 2'b01;
                ALU_CO_o       = 2'b10;
                is_immediate_o = 1'b1;
            end
            S_ALUWB:    reg_wr_raw = 1'b1;
            S_BRANCH: begin
                alu_src_a_o = 2'b10;
                ALU_CO_o    = 2'b01;
                branch      = 1'b1;
            end
            S_JAL: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_update   = 1'b1;
            end
            S_JALR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
            end
            S_LUI: begin
                alu_src_a_o = 2'b11;
                alu_src_b_o = 2'b01;
            end
            default: ;
        endcase
    end

    // Write enables and pulses are suppressed during reset and on timeout.
    assign pc_write_o      = !rst_i && !timeout
                          && (pc_update || (branch && branch_taken_i));
    assign ir_write_o      = !rst_i && !timeout && ir_wr_raw;
    assign mem_write_o     = !rst_i && !timeout && mem_wr_raw;
    assign reg_write_o     = !rst_i && !timeout && reg_wr_raw;
    assign illegal_instr_o = !rst_i && illegal;
    assign bus_error_o     = !rst_i && timeout;
    assign state_o         = state_q;

endmodule

// File: tb/tb_rv_multicycle_control.sv
// Directed scoreboard bench for rv_multicycle_control.
// Covers both the unlimited-wait and STALL_LIMIT=4 configurations.
module tb_rv_multicycle_control;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3;
    localparam logic [3:0] MB = 4'd4, MW = 4'd5, XR = 4'd6, XI = 4'd7;
    localparam logic [3:0] WB = 4'd8, BR = 4'd9, JL = 4'd10, JR = 4'd11;
    localparam logic [3:0] LU = 4'd12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       rdy = 1'b0;
    logic       tk = 1'b0;

    logic       pcw [2], irw [2], adr [2], mw [2], rw [2];
    logic [1:0] sa [2], sb [2], rs [2], co [2];
    logic       imm [2], ill [2], berr [2];
    logic [3:0] st [2];

    int checks = 0;
    int errors = 0;
    logic [19:0] exq[$];

    always #5 clk = ~clk;

    rv_multicycle_control #(.STALL_LIMIT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .opcode_i(op), .mem_ready_i(rdy),
        .branch_taken_i(tk), .pc_write_o(pcw[0]), .ir_write_o(irw[0]),
        .adr_src_o(adr[0]), .mem_write_o(mw[0]), .reg_write_o(rw[0]),
        .alu_src_a_o(sa[0]), .alu_src_b_o(sb[0]), .result_src_o(rs[0]),
        .ALU_CO_o(co[0]), .is_immediate_o(imm[0]),
        .illegal_instr_o(ill[0]), .bus_error_o(berr[0]), .state_o(st[0]));

    rv_multicycle_control #(.STALL_LIMIT(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .opcode_i(op), .mem_ready_i(rdy),
        .branch_taken_i(tk), .pc_write_o(pcw[1]), .ir_write_o(irw[1]),
        .adr_src_o(adr[1]), .mem_write_o(mw[1]), .reg_write_o(rw[1]),
        .alu_src_a_o(sa[1]), .alu_src_b_o(sb[1]), .result_src_o(rs[1]),
        .ALU_CO_o(co[1]), .is_immediate_o(imm[1]),
        .illegal_instr_o(ill[1]), .bus_error_o(berr[1]), .state_o(st[1]));

    // {state, pcw, irw, adr, mw, rw, a, b, rsrc, co, imm, ill, berr}
    function automatic logic [19:0] model(input logic [3:0] s,
        input logic r, input logic t, input logic il, input logic be,
        input logic rs_in);
        logic p = 0, i = 0, ad = 0, m = 0, w = 0, im = 0;
        logic [1:0] a = 0, b = 0, res = 0, c = 0;
        case (s)
            FE: begin b = 2'b10; res = 2'b10; p = r; i = r; end
            DE: begin a = 2'b01; b = 2'b01; end
            MA: begin a = 2'b10; b = 2'b01; end
            MR: ad = 1'b1;
            MB: begin res = 2'b01; w = 1'b1; end
            MW: begin ad = 1'b1; m = 1'b1; end
            XR: begin a = 2'b10; c = 2'b10; end
            XI: begin a = 2'b10; b = 2'b01; c = 2'b10; im = 1'b1; end
            WB: w = 1'b1;
            BR: begin a = 2'b10; c = 2'b01; p = t; end
            JL: begin a = 2'b01; b = 2'b10; p = 1'b1; end
            JR: begin a = 2'b10; b = 2'b01; end
            LU: begin a = 2'b11; b = 2'b01; end
            default: ;
        endcase
        if (rs_in || be) begin p = 0; i = 0; m = 0; w = 0; end
        return {s, p, i, ad, m, w, a, b, res, c, im, il, be};
    endfunction

    // One clock step: drive, push expectation, compare mid-cycle.
    task automatic cyc(input string tag, input int sel,
        input logic [3:0] s, input logic r, input logic t,
        input logic il, input logic be, input logic rs_in);
        logic [19:0] exp_v, obs;
        rdy = r;
        tk  = t;
        rst = rs_in;
        exq.push_back(model(s, r, t, il, be, rs_in));
        @(negedge clk);
        exp_v = exq.pop_front();
        obs = {st[sel], pcw[sel], irw[sel], adr[sel], mw[sel], rw[sel],
               sa[sel], sb[sel], rs[sel], co[sel], imm[sel], ill[sel],
               berr[sel]};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc("reset", 0, FE, 1, 0, 0, 0, 1);

        op = 7'b0110011;
        cyc("r_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("r_decode", 0, DE, 1, 1, 0, 0, 0);
        cyc("r_exec", 0, XR, 1, 1, 0, 0, 0);
        cyc("r_wb", 0, WB, 1, 0, 0, 0, 0);

        op = 7'b0010011;
        cyc("i_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("i_decode", 0, DE, 1, 0, 0, 0, 0);
        cyc("i_exec", 0, XI, 1, 0, 0, 0, 0);
        cyc("i_wb", 0, WB, 1, 0, 0, 0, 0);

        op = 7'b0000011;
        cyc("ld_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("ld_decode", 0, DE, 1, 0, 0, 0, 0);
        cyc("ld_adr", 0, MA, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc("ld_wait", 0, MR, 0, 0, 0, 0, 0);
        cyc("ld_done", 0, MR, 1, 0, 0, 0, 0);
        cyc("ld_wb", 0, MB, 1, 0, 0, 0, 0);

        op = 7'b0100011;
        for (int k = 0; k < 6; k++)
            cyc("st_fetch_nolimit", 0, FE, 0, 0, 0, 0, 0);
        cyc("st_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("st_decode", 0, DE, 1, 0, 0, 0, 0);
        cyc("st_adr", 0, MA, 1, 0, 0, 0, 0);
        cyc("st_wait", 0, MW, 0, 0, 0, 0, 0);
        cyc("st_done", 0, MW, 1, 0, 0, 0, 0);

        op = 7'b1100011;
        cyc("bt_fetch", 0, FE, 1, 1, 0, 0, 0);
        cyc("bt_decode", 0, DE, 1, 1, 0, 0, 0);
        cyc("bt_branch", 0, BR, 1, 1, 0, 0, 0);
        cyc("bn_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("bn_decode", 0, DE, 1, 0, 0, 0, 0);
        cyc("bn_branch", 0, BR, 1, 0, 0, 0, 0);

        op = 7'b1100111;
        cyc("jr_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("jr_decode", 0, DE, 1, 0, 0, 0, 0);
        cyc("jr_jalr", 0, JR, 1, 0, 0, 0, 0);
        cyc("jr_jal", 0, JL, 1, 0, 0, 0, 0);
        cyc("jr_wb", 0, WB, 1, 0, 0, 0, 0);

        op = 7'b0110111;
        cyc("lui_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("lui_decode", 0, DE, 1, 0, 0, 0, 0);
        cyc("lui_exec", 0, LU, 1, 0, 0, 0, 0);
        cyc("lui_wb", 0, WB, 1, 0, 0, 0, 0);

        op = 7'b0010111;
        cyc("auipc_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("auipc_decode", 0, DE, 1, 0, 0, 0, 0);
        cyc("auipc_wb", 0, WB, 1, 0, 0, 0, 0);

        op = 7'b1111111;
        cyc("ill_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("ill_decode", 0, DE, 1, 0, 1, 0, 0);
        cyc("ill_back", 0, FE, 0, 0, 0, 0, 0);

        op = 7'b0100011;
        cyc("rst_fetch", 0, FE, 1, 0, 0, 0, 0);
        cyc("rst_decode", 0, DE, 1, 0, 0, 0, 0);
        cyc("rst_adr", 0, MA, 1, 0, 0, 0, 0);
        cyc("rst_memwrite", 0, MW, 0, 0, 0, 0, 0);
        cyc("rst_abort", 0, FE, 1, 0, 0, 0, 1);

        for (int k = 0; k < 3; k++)
            cyc("to_fetch_wait", 1, FE, 0, 0, 0, 0, 0);
        cyc("to_fetch_err", 1, FE, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++)
            cyc("to_cleared", 1, FE, 0, 0, 0, 0, 0);
        cyc("to_ready_wins", 1, FE, 1, 0, 0, 0, 0);
        op = 7'b0000011;
        cyc("to_ld_decode", 1, DE, 1, 0, 0, 0, 0);
        cyc("to_ld_adr", 1, MA, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc("to_ld_wait", 1, MR, 0, 0, 0, 0, 0);
        cyc("to_ld_err", 1, MR, 0, 0, 0, 1, 0);
        op = 7'b0100011;
        cyc("to_st_fetch", 1, FE, 1, 0, 0, 0, 0);
        cyc("to_st_decode", 1, DE, 1, 0, 0, 0, 0);
        cyc("to_st_adr", 1, MA, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc("to_st_wait", 1, MW, 0, 0, 0, 0, 0);
        cyc("to_st_err", 1, MW, 0, 0, 0, 1, 0);
        cyc("to_st_back", 1, FE, 1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
